if_id_decode: RTL
=================

// Module: if_id_decode
// PURPOSE
//  IF/ID pipeline register plus decode stage of the 8-bit MIPS core; sits directly downstream of the fetch stage.
//  Fetch supplies PC and instruction memory. This block latches its 24-bit instruction and 8-bit address.
//  It decodes control fields and drives a registered ID/EX bundle.
//  It feeds back Stall, Stall_pm, pc_mux_sel and jmp_loc to fetch for load-use hazards and jumps.
// PARAMETERS
//  INS_W   24  instruction width
//  ADDR_W  8   PC / jump-target width
//  REG_AW  3   register-index width (8 GPRs)
// PORTS
//  clk          in   1       rising-edge clock, single domain
//  reset        in   1       synchronous, active-low; 0 at a rising edge clears all state
//  ins          in   24      instruction word from fetch
//  pc_in        in   8       fetch Current_Address paired with ins
//  Stall        out  1       hold PC (to fetch)
//  Stall_pm     out  1       hold fetched instruction (to fetch)
//  pc_mux_sel   out  1       1 = fetch takes jmp_loc
//  jmp_loc      out  8       jump target
//  ex_valid     out  1       ID/EX slot holds a real instruction
//  ex_opcode    out  5       ID/EX opcode
//  ex_rd/ex_rs1/ex_rs2 out 3 each  register indices
//  ex_imm       out  8       ins[7:0]
//  ex_pc        out  8       PC of ID/EX instruction
//  ex_alu_op    out  3       0 ADD,1 SUB,2 AND,3 OR,4 XOR
//  ex_alu_imm   out  1       ALU B operand = ex_imm
//  ex_reg_write, ex_mem_read, ex_mem_write  out 1 each
//  illegal_op   out  1       one-cycle pulse: undefined opcode retired as NOP
// BEHAVIOUR
//  Format: [23:19] opcode, [18:16] rd, [15:13] rs1, [12:10] rs2, [9:8] zero, [7:0] imm/target.
//  Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR.
//   06 ADDI (rs1+imm). 07 LD rd<-M[rs1+imm]. 08 ST M[rs1+imm]<-rs2. 09 JMP imm. Others are illegal.
//  Reset (reset=0 at edge): IF/ID valid=0, ins=0. All ex_* =0. flush_pending=0.
//   Combinational Stall/Stall_pm/pc_mux_sel=0 and jmp_loc=0 follow in the same cycle.
//  IF/ID register: loads {ins,pc_in,valid=1} each edge unless hold or squash.
//   hold (hazard): keeps its contents.
//   squash: loads NOP with valid=0.
//  Uses: rs1 for ALU/ADDI/LD/ST. rs2 for ALU/ST. JMP and NOP read nothing.
//  Load-use hazard, combinational:
//   Condition: ex_valid & ex_mem_read & IF/ID valid & IF/ID uses a register equal to ex_rd.
//   Response: Stall=Stall_pm=1 that cycle.
//   IF/ID holds; ID/EX loads a bubble (all ex_* =0).
//   Lasts exactly one cycle, because the bubble clears ex_mem_read.
//  Jump, combinational:
//   Condition: IF/ID valid & opcode JMP & no hazard.
//   Response: pc_mux_sel=1 and jmp_loc=IF/ID imm.
//   JMP itself passes to ID/EX with no writes.
//   Next edge sets flush_pending. The instruction word arriving while flush_pending=1 is squashed.
//   flush_pending then clears.
//  Two consecutive JMPs: the second is squashed; only the first redirects.
//  ID/EX register:
//   Normal: registered decode of IF/ID. Invalid IF/ID yields a bubble.
//   Illegal opcode: NOP with ex_valid=1; illegal_op=1 for that cycle.
//   ex_reg_write=1 for ALU/ADDI/LD. Writes to r0 are allowed (no hardwired zero).
//  Latency: instruction latched in IF/ID at edge N appears on ex_* after edge N+1.
//  Reset mid-stall or mid-flush: all state cleared; no pending squash survives.
// STRUCTURE
//  Shared include mips8_defs.vh:
//   opcode localparams, field bit positions, ALU op codes, NOP word.
//  Sub-module hazard_unit: compares IF/ID sources with ex_rd/ex_mem_read.
//   Outputs stall, jump and squash decisions.
//  Top level holds IF/ID, ID/EX and flush_pending flops plus the decoder case.
// TESTING
//  1. reset=0 for 2 clk with ins=24'hFFFFFF -> all ex_*=0, Stall=0, pc_mux_sel=0, illegal_op=0.
//  2. ADD r1,r2,r3 at pc 5 -> one edge later ex_opcode=1, ex_rd=1, ex_rs1=2, ex_rs2=3, ex_reg_write=1, ex_pc=5.
//  3. LD r2,[r1+4] then ADD r3,r2,r0 -> Stall=Stall_pm=1 one cycle.
//   ID/EX shows a bubble; the ADD emerges the following cycle.
//   Stall does not repeat.
//  4. LD r2 then ADD r3,r4,r5 (no dependency) -> no stall; back-to-back issue.
//  5. JMP 8'h40 -> pc_mux_sel=1, jmp_loc=8'h40 one cycle.
//   Next arriving word squashed (ex_valid=0); the word from 8'h40 issues after.
//  6. JMP followed by JMP -> only the first redirects.
//   Opcode 5'h1F -> illegal_op pulse, ex_reg_write=0.
//   reset during a hazard -> Stall drops the same cycle.

Source files
------------

// File: rtl/if_id_decode_pkg.sv
// Shared definitions for the 8-bit MIPS IF/ID + decode slice: instruction
// field positions, opcodes, ALU operation codes and the ID/EX bundle type.
package if_id_decode_pkg;

  localparam int INS_W  = 24;
  localparam int ADDR_W = 8;
  localparam int REG_AW = 3;
  localparam int OP_W   = 5;

  // Instruction field bit positions
  localparam int OP_HI  = 23;
  localparam int OP_LO  = 19;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 16;
  localparam int RS1_HI = 15;
  localparam int RS1_LO = 13;
  localparam int RS2_HI = 12;
  localparam int RS2_LO = 10;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OP_ADD  = 5'h01;
  localparam logic [OP_W-1:0] OP_SUB  = 5'h02;
  localparam logic [OP_W-1:0] OP_AND  = 5'h03;
  localparam logic [OP_W-1:0] OP_OR   = 5'h04;
  localparam logic [OP_W-1:0] OP_XOR  = 5'h05;
  localparam logic [OP_W-1:0] OP_ADDI = 5'h06;
  localparam logic [OP_W-1:0] OP_LD   = 5'h07;
  localparam logic [OP_W-1:0] OP_ST   = 5'h08;
  localparam logic [OP_W-1:0] OP_JMP  = 5'h09;

  localparam logic [INS_W-1:0] NOP_WORD = 24'h000000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] pc;
    alu_op_t           alu_op;
    logic              alu_imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_bundle_t;

  // ALU ops, ADDI, LD and ST all read rs1
  function automatic logic reads_rs1(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ST);
  endfunction

  // Register-register ALU ops and ST (store data) read rs2
  function automatic logic reads_rs2(input logic [OP_W-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_XOR)) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/if_id_decode_hazard.sv
// Hazard/redirect decisions for the IF/ID stage: load-use stall against the
// load sitting in ID/EX, jump redirect, and squash of wrong-path words.
module hazard_unit
  import if_id_decode_pkg::*;
(
  input  logic              reset,
  input  logic              ifid_valid,
  input  logic [OP_W-1:0]   ifid_opcode,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              flush_pending,
  output logic              stall,
  output logic              jump,
  output logic              squash
);

  logic raw_hazard;

  // Stall/jump/squash decisions; all forced low while reset is asserted
  always_comb begin
    raw_hazard = ex_valid & ex_mem_read & ifid_valid &
                 ((reads_rs1(ifid_opcode) & (ifid_rs1 == ex_rd)) |
                  (reads_rs2(ifid_opcode) & (ifid_rs2 == ex_rd)));
    stall  = reset & raw_hazard;
    jump   = reset & ifid_valid & (ifid_opcode == OP_JMP) & ~raw_hazard;
    // The word arriving alongside a redirect, and the one after, are wrong-path
    squash = jump | flush_pending;
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register and decode stage of the 8-bit MIPS core. Holds the
// IF/ID, ID/EX and flush_pending flops; feeds stall/jump control back to fetch.
module if_id_decode
  import if_id_decode_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  ins,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              Stall,
  output logic              Stall_pm,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [7:0]        ex_imm,
  output logic [ADDR_W-1:0] ex_pc,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              illegal_op
);

  logic              ifid_valid_r;
  logic [INS_W-1:0]  ifid_ins_r;
  logic [ADDR_W-1:0] ifid_pc_r;
  logic              flush_pending_r;
  ex_bundle_t        ex_r;
  ex_bundle_t        ex_next;
  logic              illegal_r;
  logic              illegal_next;
  logic              stall;
  logic              jump;
  logic              squash;
  logic [OP_W-1:0]   ifid_op;
  logic              unused_zero_bits;

  assign ifid_op          = ifid_ins_r[OP_HI:OP_LO];
  assign unused_zero_bits = ^ifid_ins_r[9:8];

  hazard_unit u_hazard (
    .reset         (reset),
    .ifid_valid    (ifid_valid_r),
    .ifid_opcode   (ifid_op),
    .ifid_rs1      (ifid_ins_r[RS1_HI:RS1_LO]),
    .ifid_rs2      (ifid_ins_r[RS2_HI:RS2_LO]),
    .ex_valid      (ex_r.valid),
    .ex_mem_read   (ex_r.mem_read),
    .ex_rd         (ex_r.rd),
    .flush_pending (flush_pending_r),
    .stall         (stall),
    .jump          (jump),
    .squash        (squash)
  );

  // IF/ID register: load, hold on hazard, or squash to an invalid NOP
  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_valid_r    <= 1'b0;
      ifid_ins_r      <= NOP_WORD;
      ifid_pc_r       <= 8'h00;
      flush_pending_r <= 1'b0;
    end else begin
      flush_pending_r <= jump;
      if (stall) begin
        ifid_valid_r <= ifid_valid_r;
        ifid_ins_r   <= ifid_ins_r;
        ifid_pc_r    <= ifid_pc_r;
      end else if (squash) begin
        ifid_valid_r <= 1'b0;
        ifid_ins_r   <= NOP_WORD;
        ifid_pc_r    <= 8'h00;
      end else begin
        ifid_valid_r <= 1'b1;
        ifid_ins_r   <= ins;
        ifid_pc_r    <= pc_in;
      end
    end
  end

  // Decoder: IF/ID word to next ID/EX bundle; bubble when stalled or invalid
  always_comb begin
    ex_next      = '0;
    illegal_next = 1'b0;
    if (ifid_valid_r && !stall) begin
      ex_next.valid = 1'b1;
      ex_next.pc    = ifid_pc_r;
      if (ifid_op <= OP_JMP) begin
        ex_next.opcode = ifid_op;
        ex_next.rd     = ifid_ins_r[RD_HI:RD_LO];
        ex_next.rs1    = ifid_ins_r[RS1_HI:RS1_LO];
        ex_next.rs2    = ifid_ins_r[RS2_HI:RS2_LO];
        ex_next.imm    = ifid_ins_r[IMM_HI:IMM_LO];
        case (ifid_op)
          OP_ADD:  begin ex_next.alu_op = ALU_ADD; ex_next.reg_write = 1'b1; end
          OP_SUB:  begin ex_next.alu_op = ALU_SUB; ex_next.reg_write = 1'b1; end
          OP_AND:  begin ex_next.alu_op = ALU_AND; ex_next.reg_write = 1'b1; end
          OP_OR:   begin ex_next.alu_op = ALU_OR;  ex_next.reg_write = 1'b1; end
          OP_XOR:  begin ex_next.alu_op = ALU_XOR; ex_next.reg_write = 1'b1; end
          OP_ADDI: begin ex_next.alu_imm = 1'b1; ex_next.reg_write = 1'b1; end
          OP_LD: begin
            ex_next.alu_imm   = 1'b1;
            ex_next.reg_write = 1'b1;
            ex_next.mem_read  = 1'b1;
          end
          OP_ST: begin
            ex_next.alu_imm   = 1'b1;
            ex_next.mem_write = 1'b1;
          end
          default: ex_next.alu_op = ALU_ADD;  // NOP and JMP: no side effects
        endcase
      end else begin
        // Undefined opcode retires as a NOP that still occupies the slot
        illegal_next = 1'b1;
      end
    end else begin
      ex_next      = '0;
      illegal_next = 1'b0;
    end
  end

  // ID/EX register and the one-cycle illegal-opcode pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      ex_r      <= ex_next;
      illegal_r <= illegal_next;
    end
  end

  assign Stall        = stall;
  assign Stall_pm     = stall;
  assign pc_mux_sel   = jump;
  assign jmp_loc      = jump ? ifid_ins_r[IMM_HI:IMM_LO] : 8'h00;
  assign ex_valid     = ex_r.valid;
  assign ex_opcode    = ex_r.opcode;
  assign ex_rd        = ex_r.rd;
  assign ex_rs1       = ex_r.rs1;
  assign ex_rs2       = ex_r.rs2;
  assign ex_imm       = ex_r.imm;
  assign ex_pc        = ex_r.pc;
  assign ex_alu_op    = ex_r.alu_op;
  assign ex_alu_imm   = ex_r.alu_imm;
  assign ex_reg_write = ex_r.reg_write;
  assign ex_mem_read  = ex_r.mem_read;
  assign ex_mem_write = ex_r.mem_write;
  assign illegal_op   = illegal_r;

endmodule
